// File: rtl/counter_mod_ud.sv
// Modulo-MOD up/down counter with sync clear/load, count enable and cascade carry.
// Latency: q updates one clock after the enabling inputs; tc/co are combinational.
// No backpressure: en & cin gate counting; co chains to the next stage's cin.
// Optional build macro COUNTER_SAT_EN: saturate at the terminal value instead of wrapping.

module counter_mod_ud #(
  parameter int MOD   = 12,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cin,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             err
);

  // A modulus outside 2..2^WIDTH cannot be represented on q.
  generate
    if ((MOD < 2) || (MOD > (2 ** WIDTH))) begin : g_bad_mod
      $error("counter_mod_ud: MOD=%0d is outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end
  endgenerate

  // One extra bit so q+1 and MOD itself fit when MOD == 2^WIDTH.
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] Q_ZERO = '0;

`ifdef COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   load_x;
  logic             load_bad;
  logic [WIDTH-1:0] q_up;
  logic [WIDTH-1:0] q_dn;

  assign q_inc    = {1'b0, q} + (WIDTH+1)'(1);
  assign load_x   = {1'b0, load_val};
  assign load_bad = (load_x >= MOD_X);

  // Next value when counting up: wrap (or hold) once q+1 reaches MOD.
  always_comb begin
    q_up = q_inc[WIDTH-1:0];
    if (q_inc == MOD_X) begin
      q_up = SAT ? Q_MAX : Q_ZERO;
    end
  end

  // Next value when counting down: wrap to MOD-1 (or hold) from zero.
  always_comb begin
    q_dn = q - WIDTH'(1);
    if (q == Q_ZERO) begin
      q_dn = SAT ? Q_ZERO : Q_MAX;
    end
  end

  // Terminal count follows the current direction so a chain sees carry or borrow.
  assign tc = up_dn ? (q == Q_MAX) : (q == Q_ZERO);
  assign co = en & cin & tc;

  // Count state: clear beats load beats count; err latches illegal loads until clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q   <= '0;
      err <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      err <= 1'b0;
    end else if (load) begin
      if (load_bad) begin
        q   <= Q_MAX;
        err <= 1'b1;
      end else begin
        q   <= load_val;
      end
    end else if (en && cin) begin
      q <= up_dn ? q_up : q_dn;
    end
  end

endmodule
